// File: rtl/mul_controller.sv
// Control FSM for a shift-free repeated-add multiplier.
// Sequences operand loads, the A+P accumulate loop and the result handshake.
module mul_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eqz,
  output logic             load_A,
  output logic             load_B,
  output logic             clrP,
  output logic             load_P,
  output logic             decB,
  output logic             done,
  output logic             busy,
  input  logic             res_ready,
  output logic [WIDTH-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t nxt;
  logic   clr_it;
  logic   inc_it;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Saturates so a runaway loop never wraps back to a small count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      iter_count <= '0;
    else if (clr_it)
      iter_count <= '0;
    else if (inc_it && iter_count != '1)
      iter_count <= iter_count + 1'b1;
  end

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    load_A   = 1'b0;
    load_B   = 1'b0;
    clrP     = 1'b0;
    load_P   = 1'b0;
    decB     = 1'b0;
    done     = 1'b0;
    clr_it   = 1'b0;
    inc_it   = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) nxt = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (abort) begin
          nxt = IDLE;
        end else if (in_valid) begin
          load_A = 1'b1;
          nxt    = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (abort) begin
          nxt = IDLE;
        end else if (in_valid) begin
          load_B = 1'b1;
          clrP   = 1'b1;
          clr_it = 1'b1;
          nxt    = ADD;
        end
      end
      ADD: begin
        if (abort) begin
          nxt = IDLE;
        end else if (eqz) begin
          nxt = DONE;
        end else begin
          load_P = 1'b1;
          decB   = 1'b1;
          inc_it = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (abort || res_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
